// File: rtl/pixel_seq_pkg.sv
// rtl/pixel_seq_pkg.sv - shared state type, ramp length and Gray helper for the pixel frame sequencer
package pixel_seq_pkg;

  // Default ADC code width and the matching convert-phase length.
  localparam int ADC_W_DEF = 8;
  localparam int CONV_CYC  = 1 << ADC_W_DEF;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ERASE   = 3'd1,
    ST_EXPOSE  = 3'd2,
    ST_CONVERT = 3'd3,
    ST_READ    = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  // Works for code widths up to 32 bits; callers truncate to their own width.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/pixel_seq_ctrl_if.sv
// rtl/pixel_seq_ctrl_if.sv - row readout bus between the sequencer and the databus
// Ports (modport master = sequencer side):
//   read_en   one-hot row select
//   row_valid selected row is on the databus
//   row_idx   index of the selected row
//   row_ready downstream accepts the current row
interface pixel_seq_ctrl_if #(
  parameter int N_ROWS = 2
);
  localparam int RW = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;

  logic [N_ROWS-1:0] read_en;
  logic              row_valid;
  logic [RW-1:0]     row_idx;
  logic              row_ready;

  modport master (output read_en, row_valid, row_idx, input row_ready);
  modport slave  (input read_en, row_valid, row_idx, output row_ready);
endinterface

// File: rtl/adc_ramp_counter.sv
// rtl/adc_ramp_counter.sv - shared ADC ramp code counter, binary or Gray output
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   en          advance the ramp by one code this cycle
//   clr         return the ramp to code 0 (wins over en)
//   code        current ramp code (Gray when GRAY=1)
//   last        binary count is at its final value
module adc_ramp_counter
  import pixel_seq_pkg::*;
#(
  parameter int ADC_W = 8,
  parameter bit GRAY  = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  output logic [ADC_W-1:0] code,
  output logic             last
);

  logic [ADC_W-1:0] k;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      k <= '0;
    end else if (en) begin
      k <= k + 1'b1;
    end
  end

  assign code = GRAY ? ADC_W'(bin2gray(32'(k))) : k;
  assign last = &k;

endmodule

// File: rtl/pixel_seq_ctrl.sv
// rtl/pixel_seq_ctrl.sv - frame sequencer: erase, expose, convert, row-by-row readout
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   start        frame request, honoured only while idle
//   cont_mode    run frames back to back (sampled in IDLE and DONE)
//   expose_len   exposure length in cycles, latched at frame start (0 acts as 1)
//   erase/expose/convert  pixel phase strobes
//   adc_code     ramp code broadcast during convert, 0 otherwise
//   busy         high whenever not idle
//   frame_done   one-cycle pulse in the last cycle of a frame
//   frame_cnt    completed frame count, wraps at 16 bits
//   rbus         row readout bus (read_en, row_valid, row_idx, row_ready)
module pixel_seq_ctrl
  import pixel_seq_pkg::*;
#(
  parameter int N_ROWS    = 2,
  parameter int ADC_W     = ADC_W_DEF,
  parameter int ERASE_CYC = 5,
  parameter int EXP_W     = 16,
  parameter bit GRAY      = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                cont_mode,
  input  logic [EXP_W-1:0]    expose_len,
  output logic                erase,
  output logic                expose,
  output logic                convert,
  output logic [ADC_W-1:0]    adc_code,
  output logic                busy,
  output logic                frame_done,
  output logic [15:0]         frame_cnt,
  pixel_seq_ctrl_if.master    rbus
);

  localparam int RW = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
  localparam int EW = $clog2(ERASE_CYC + 1);
  // One timer serves both erase and expose, so it is sized for the longer one.
  localparam int TW = (EXP_W > EW) ? EXP_W : EW;
  localparam logic [TW-1:0] ERASE_LAST = TW'(ERASE_CYC - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(N_ROWS - 1);

  state_e           state;
  logic [TW-1:0]    timer;
  logic [EXP_W-1:0] exp_q;
  logic [RW-1:0]    row;
  logic [EXP_W-1:0] latch_len;
  logic [TW-1:0]    exp_last;
  logic             ramp_en;
  logic             ramp_clr;
  logic             ramp_last;

  assign latch_len = (expose_len == '0) ? EXP_W'(1) : expose_len;
  assign exp_last  = TW'(exp_q) - TW'(1);

  // The ramp runs only in CONVERT and is cleared on its final code, so it
  // is back at 0 (and adc_code reads 0) for the rest of the frame.
  assign ramp_en  = (state == ST_CONVERT);
  assign ramp_clr = ramp_en && ramp_last;

  adc_ramp_counter #(
    .ADC_W (ADC_W),
    .GRAY  (GRAY)
  ) u_ramp (
    .clk   (clk),
    .reset (reset),
    .en    (ramp_en),
    .clr   (ramp_clr),
    .code  (adc_code),
    .last  (ramp_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      timer     <= '0;
      exp_q     <= '0;
      row       <= '0;
      frame_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start || cont_mode) begin
            state <= ST_ERASE;
            timer <= '0;
            exp_q <= latch_len;
          end
        end
        ST_ERASE: begin
          if (timer == ERASE_LAST) begin
            state <= ST_EXPOSE;
            timer <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_EXPOSE: begin
          if (timer == exp_last) begin
            state <= ST_CONVERT;
            timer <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_CONVERT: begin
          if (ramp_last) begin
            state <= ST_READ;
          end
        end
        ST_READ: begin
          if (rbus.row_ready) begin
            if (row == ROW_LAST) begin
              state <= ST_DONE;
              row   <= '0;
            end else begin
              row <= row + 1'b1;
            end
          end
        end
        ST_DONE: begin
          frame_cnt <= frame_cnt + 1'b1;
          if (cont_mode) begin
            state <= ST_ERASE;
            timer <= '0;
            exp_q <= latch_len;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // All outputs decode the registered state, so they change only on clk.
  assign erase      = (state == ST_ERASE);
  assign expose     = (state == ST_EXPOSE);
  assign convert    = (state == ST_CONVERT);
  assign busy       = (state != ST_IDLE);
  assign frame_done = (state == ST_DONE);

  assign rbus.row_valid = (state == ST_READ);
  assign rbus.read_en   = rbus.row_valid ? (N_ROWS'(1) << row) : '0;
  assign rbus.row_idx   = row;

endmodule

// File: tb/tb_pixel_seq_ctrl.sv
// tb/tb_pixel_seq_ctrl.sv - directed and randomized bench for pixel_seq_ctrl against a frame-offset model
module tb_pixel_seq_ctrl;
  import pixel_seq_pkg::*;

  localparam int N_ROWS    = 2;
  localparam int ADC_W     = 8;
  localparam int ERASE_CYC = 5;
  localparam int EXP_W     = 16;
  localparam bit GRAY      = 1'b1;
  localparam int CONV      = CONV_CYC;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             cont_mode = 1'b0;
  logic [EXP_W-1:0] expose_len = '0;
  logic             erase, expose, convert, busy, frame_done;
  logic [ADC_W-1:0] adc_code;
  logic [15:0]      frame_cnt;

  pixel_seq_ctrl_if #(.N_ROWS(N_ROWS)) rb();

  pixel_seq_ctrl #(
    .N_ROWS(N_ROWS), .ADC_W(ADC_W), .ERASE_CYC(ERASE_CYC), .EXP_W(EXP_W), .GRAY(GRAY)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .cont_mode(cont_mode),
    .expose_len(expose_len), .erase(erase), .expose(expose), .convert(convert),
    .adc_code(adc_code), .busy(busy), .frame_done(frame_done), .frame_cnt(frame_cnt),
    .rbus(rb)
  );

  always #5 clk = ~clk;

  // Model: a frame is an offset d counted from its launch edge (d=1 is the
  // first erase cycle) plus the number of rows already transferred.
  bit          m_active = 1'b0;
  int          m_d = 0;
  int          m_e = 0;
  int          m_rows = 0;
  logic [15:0] m_cnt = '0;

  // 0 idle, 1 erase, 2 expose, 3 convert, 4 read, 5 done
  function automatic int m_phase();
    if (!m_active) return 0;
    if (m_d <= ERASE_CYC) return 1;
    if (m_d <= ERASE_CYC + m_e) return 2;
    if (m_d <= ERASE_CYC + m_e + CONV) return 3;
    if (m_rows < N_ROWS) return 4;
    return 5;
  endfunction

  always @(posedge clk) begin
    int ph;
    ph = m_phase();
    if (reset) begin
      m_active = 1'b0; m_d = 0; m_rows = 0; m_cnt = '0; m_e = 0;
    end else if (!m_active) begin
      if (start || cont_mode) begin
        m_active = 1'b1; m_d = 1; m_rows = 0;
        m_e = (expose_len == 0) ? 1 : int'(expose_len);
      end
    end else if (ph == 5) begin
      m_cnt = m_cnt + 16'd1;
      if (cont_mode) begin
        m_d = 1; m_rows = 0;
        m_e = (expose_len == 0) ? 1 : int'(expose_len);
      end else begin
        m_active = 1'b0;
      end
    end else begin
      if (ph == 4 && rb.row_ready) m_rows++;
      m_d++;
    end
  end

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    int ph;
    int k;
    if (chk_en) begin
      ph = m_phase();
      k  = m_d - ERASE_CYC - m_e - 1;
      check("erase", erase, ph == 1);
      check("expose", expose, ph == 2);
      check("convert", convert, ph == 3);
      check("adc_code", adc_code, (ph == 3) ? (k ^ (k >> 1)) : 0);
      check("row_valid", rb.row_valid, ph == 4);
      check("read_en", rb.read_en, (ph == 4) ? (1 << m_rows) : 0);
      if (ph == 4) check("row_idx", rb.row_idx, m_rows);
      check("busy", busy, m_active);
      check("frame_done", frame_done, ph == 5);
      check("frame_cnt", frame_cnt, m_cnt);
    end
  end

  // Observed-behaviour statistics for the literal expectations.
  int cyc, n_erase, n_expose, n_conv, n_row0, n_row1, n_done, done_at, n_idle, cur_exp;
  logic [ADC_W-1:0] codes[$];
  int exp_hist[$];

  always @(negedge clk) begin
    cyc++;
    if (erase) n_erase++;
    if (expose) begin n_expose++; cur_exp++; end
    if (convert) begin n_conv++; codes.push_back(adc_code); end
    if (rb.read_en == 2'b01) n_row0++;
    if (rb.read_en == 2'b10) n_row1++;
    if (!busy) n_idle++;
    if (frame_done) begin
      n_done++;
      if (done_at < 0) done_at = cyc;
      exp_hist.push_back(cur_exp);
      cur_exp = 0;
    end
  end

  task automatic clear_stats();
    cyc = 0; n_erase = 0; n_expose = 0; n_conv = 0; n_row0 = 0; n_row1 = 0;
    n_done = 0; done_at = -1; n_idle = 0; cur_exp = 0;
    codes.delete(); exp_hist.delete();
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input int n, input int limit);
    for (int i = 0; i < limit && n_done < n; i++) step();
    if (n_done < n) check("wait_done timeout", n_done, n);
  endtask

  initial begin
    int gexp[5];
    gexp = '{0, 1, 3, 2, 6};
    rb.row_ready = 1'b1;
    clear_stats();

    reset = 1'b1;
    repeat (3) step();
    chk_en = 1'b1;
    reset = 1'b0;
    step();
    check("reset busy", busy, 0);
    check("reset frame_cnt", frame_cnt, 0);
    check("reset read_en", rb.read_en, 0);

    // Single frame, exposure 10.
    clear_stats();
    expose_len = 10; start = 1'b1;
    step();
    start = 1'b0;
    wait_done(1, 400);
    check("t1 done cycle", done_at, 274);
    check("t1 erase cycles", n_erase, 5);
    check("t1 expose cycles", n_expose, 10);
    check("t1 convert cycles", n_conv, 256);
    check("t1 row0 cycles", n_row0, 1);
    check("t1 row1 cycles", n_row1, 1);
    check("t1 code count", codes.size(), 256);
    for (int i = 0; i < 5; i++) check("t1 gray head", codes[i], gexp[i]);
    check("t1 gray last", codes[255], 8'h80);
    for (int i = 1; i < 256; i++) check("t1 gray one bit", $countones(codes[i] ^ codes[i-1]), 1);
    step();
    check("t1 frame_cnt", frame_cnt, 1);
    check("t1 idle", busy, 0);

    // Backpressure: row 0 held for 7 cycles.
    clear_stats();
    expose_len = 3; rb.row_ready = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 400 && !rb.row_valid; i++) step();
    check("t2 row_valid reached", rb.row_valid, 1);
    repeat (7) step();
    rb.row_ready = 1'b1;
    wait_done(1, 50);
    check("t2 row0 cycles", n_row0, 8);
    check("t2 row1 cycles", n_row1, 1);

    // Exposure 0 with start held through the frame.
    clear_stats();
    expose_len = 0; start = 1'b1;
    wait_done(1, 400);
    start = 1'b0;
    repeat (6) step();
    check("t3 frames", n_done, 1);
    check("t3 expose cycles", n_expose, 1);
    check("t3 frame_cnt", frame_cnt, 3);

    // Continuous mode, three frames with changing exposure.
    reset = 1'b1; step(); reset = 1'b0; step();
    clear_stats();
    expose_len = 4; cont_mode = 1'b1;
    wait_done(1, 400);
    expose_len = 7;
    wait_done(2, 400);
    expose_len = 2;
    repeat (2) step();
    cont_mode = 1'b0;
    wait_done(3, 400);
    repeat (3) step();
    check("t4 frames", n_done, 3);
    check("t4 exp0", exp_hist[0], 4);
    check("t4 exp1", exp_hist[1], 7);
    check("t4 exp2", exp_hist[2], 2);
    check("t4 idle cycles", n_idle, 3);
    check("t4 frame_cnt", frame_cnt, 3);

    // frame_cnt wrap.
    force dut.frame_cnt = 16'hFFFF;
    m_cnt = 16'hFFFF;
    step();
    release dut.frame_cnt;
    step();
    check("wrap preset", frame_cnt, 16'hFFFF);
    clear_stats();
    expose_len = 1; start = 1'b1;
    step();
    start = 1'b0;
    wait_done(1, 400);
    step();
    check("wrap frame_cnt", frame_cnt, 0);

    // Reset in convert cycle 100, then a clean frame.
    clear_stats();
    expose_len = 5; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 400 && !convert; i++) step();
    check("t5 convert reached", convert, 1);
    repeat (99) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t5 busy", busy, 0);
    check("t5 convert", convert, 0);
    check("t5 adc_code", adc_code, 0);
    check("t5 no done", n_done, 0);
    check("t5 frame_cnt", frame_cnt, 0);
    clear_stats();
    expose_len = 10; start = 1'b1;
    step();
    start = 1'b0;
    wait_done(1, 400);
    check("t5 done cycle", done_at, 274);
    step();
    check("t5 frame_cnt after", frame_cnt, 1);

    // Randomized traffic.
    clear_stats();
    for (int i = 0; i < 4000; i++) begin
      rb.row_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) == 0) cont_mode = ~cont_mode;
      start      = ($urandom_range(0, 15) == 0);
      expose_len = EXP_W'($urandom_range(0, 12));
      reset      = ($urandom_range(0, 1999) == 0);
      step();
    end
    reset = 1'b0; start = 1'b0; cont_mode = 1'b0; rb.row_ready = 1'b1;
    for (int i = 0; i < 2000 && busy; i++) step();
    check("random drain idle", busy, 0);
    check("random frames seen", n_done > 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
